// File: rtl/crop_decimate_engine.sv
// crop_decimate_engine: walks an inclusive, optionally decimated window of a
// column-major multi-channel image. It issues one read per word, captures the
// read data after RD_LATENCY, then writes the word to a header-offset buffer
// using a ready/valid handshake.
module crop_decimate_engine #(
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100,
  parameter int CHANNELS   = 3,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int COORD_W    = 11,
  parameter int HDR_WORDS  = 54,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic [3:0]         step,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [ADDR_W-1:0]  words_out
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // The wait counter only has to reach RD_LATENCY-2.
  localparam int LAT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [CH_W-1:0]    C_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [COORD_W:0]   IMG_W_C  = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   IMG_H_C  = (COORD_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0]  IMG_H_A  = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0]  CH_A     = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0]  HDR_A    = ADDR_W'(HDR_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [3:0]         step_q, step_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CH_W-1:0]    c_q, c_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, words_q, words_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [COORD_W:0]   x_sum, y_sum;
  logic               c_last, y_wrap, x_end, last_word, cfg_bad;
  logic [COORD_W-1:0] nx, ny, ax, ay;
  logic [CH_W-1:0]    nc, ac;
  logic [ADDR_W-1:0]  addr_calc;

  // Next traversal coordinate (c fastest, then y, then x); the sums carry an
  // extra bit so a step past the window edge can never wrap around.
  always_comb begin
    y_sum     = {1'b0, y_q} + (COORD_W+1)'(step_q);
    x_sum     = {1'b0, x_q} + (COORD_W+1)'(step_q);
    c_last    = (c_q == C_LAST);
    y_wrap    = (y_sum > {1'b0, ymax_q});
    x_end     = (x_sum > {1'b0, xmax_q});
    last_word = c_last && y_wrap && x_end;
    nc        = c_q + CH_W'(1);
    ny        = y_q;
    nx        = x_q;
    if (c_last) begin
      nc = '0;
      if (y_wrap) begin
        ny = ymin_q;
        nx = x_sum[COORD_W-1:0];
      end else begin
        ny = y_sum[COORD_W-1:0];
      end
    end
    cfg_bad = (xmin_q > xmax_q) || (ymin_q > ymax_q) ||
              ({1'b0, xmax_q} >= IMG_W_C) || ({1'b0, ymax_q} >= IMG_H_C) ||
              (step_q == 4'd0);
  end

  // Source address of the coordinate about to be issued; it is the window
  // origin when leaving CHECK and the advanced coordinate otherwise.
  always_comb begin
    ax        = (state_q == S_CHECK) ? xmin_q : nx;
    ay        = (state_q == S_CHECK) ? ymin_q : ny;
    ac        = (state_q == S_CHECK) ? '0     : nc;
    addr_calc = (ADDR_W'(ax) * IMG_H_A + ADDR_W'(ay)) * CH_A + ADDR_W'(ac);
  end

  // Control FSM: next state and datapath updates.
  always_comb begin
    state_d   = state_q;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    step_d    = step_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    lat_d     = lat_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    words_d   = words_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          xmin_d    = x_min;
          xmax_d    = x_max;
          ymin_d    = y_min;
          ymax_d    = y_max;
          step_d    = step;
          wr_addr_d = HDR_A;
          words_d   = '0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_bad) begin
          state_d = S_ERR;
        end else begin
          x_d       = xmin_q;
          y_d       = ymin_q;
          c_d       = '0;
          rd_addr_d = addr_calc;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // With single-cycle latency the data is already valid here, so WAIT is skipped.
        if (RD_LATENCY == 1) begin
          wr_data_d = rd_data;
          state_d   = S_WRITE;
        end else begin
          lat_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          wr_data_d = rd_data;
          state_d   = S_WRITE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          words_d   = words_q + ADDR_W'(1);
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            x_d       = nx;
            y_d       = ny;
            c_d       = nc;
            rd_addr_d = addr_calc;
            state_d   = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      step_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      lat_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= HDR_A;
      words_q   <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      step_q    <= step_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      lat_q     <= lat_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      words_q   <= words_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy      = (state_q == S_CHECK) || (state_q == S_ISSUE) ||
                     (state_q == S_WAIT)  || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);
  assign rd_en     = (state_q == S_ISSUE);
  assign wr_en     = (state_q == S_WRITE);
  assign rd_addr   = rd_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign words_out = words_q;

endmodule
